// File: rtl/seven_seg_scanner.sv
// Multiplexed, active-low 7-segment display scanner.
// Each digit gets one slot. The slot starts with a guard window with all
// anodes off, and then the digit is driven. Display data moves from a
// pending buffer to the active set only at frame boundaries.
// Digits can be blanked or made to blink, and every output is registered.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digit_data,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_done
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0]         SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]         SLOT_ONE   = SW'(1);
    localparam logic [SW-1:0]         SLOT_ZERO  = SW'(0);
    localparam logic [SW-1:0]         GUARD_END  = SW'(GUARD);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_ONE    = IW'(1);
    localparam logic [IW-1:0]         IDX_ZERO   = IW'(0);
    localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0]         BLINK_ONE  = BW'(1);
    localparam logic [BW-1:0]         BLINK_ZERO = BW'(0);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_DARK   = 7'h7F;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

    // Scan position
    logic [SW-1:0]         slot_cnt_r;
    logic [IW-1:0]         digit_idx_r;
    // Pending buffer, written by load
    logic [DW-1:0]         pend_data_r;
    logic [NUM_DIGITS-1:0] pend_blank_r;
    logic [NUM_DIGITS-1:0] pend_blink_r;
    logic                  pend_valid_r;
    // Active set, which is what is being displayed
    logic [DW-1:0]         act_data_r;
    logic [NUM_DIGITS-1:0] act_blank_r;
    logic [NUM_DIGITS-1:0] act_blink_r;
    logic                  act_valid_r;
    // Blink timing
    logic [BW-1:0]         blink_cnt_r;
    logic                  blink_on_r;
    // Output registers
    logic [6:0]            seg_n_r;
    logic [NUM_DIGITS-1:0] an_n_r;
    logic                  frame_done_r;

    logic                  slot_wrap_s;
    logic                  frame_end_s;
    logic [SW-1:0]         slot_nxt_s;
    logic [IW-1:0]         idx_nxt_s;
    logic [DW-1:0]         pend_data_nxt_s;
    logic [NUM_DIGITS-1:0] pend_blank_nxt_s;
    logic [NUM_DIGITS-1:0] pend_blink_nxt_s;
    logic                  pend_valid_nxt_s;
    logic [DW-1:0]         act_data_nxt_s;
    logic [NUM_DIGITS-1:0] act_blank_nxt_s;
    logic [NUM_DIGITS-1:0] act_blink_nxt_s;
    logic                  act_valid_nxt_s;
    logic [BW-1:0]         blink_cnt_nxt_s;
    logic                  blink_on_nxt_s;
    logic [DW-1:0]         data_shift_s;
    logic [NUM_DIGITS-1:0] blank_shift_s;
    logic [NUM_DIGITS-1:0] blink_shift_s;
    logic [3:0]            nib_s;
    logic                  dark_s;
    logic [6:0]            seg_nxt_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;

    // Next scan position, and detection of the slot wrap and the frame boundary
    always_comb begin
        slot_wrap_s = (slot_cnt_r == SLOT_LAST);
        frame_end_s = slot_wrap_s && (digit_idx_r == IDX_LAST);
        if (slot_wrap_s) begin
            slot_nxt_s = SLOT_ZERO;
            if (digit_idx_r == IDX_LAST) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = digit_idx_r + IDX_ONE;
            end
        end else begin
            slot_nxt_s = slot_cnt_r + SLOT_ONE;
            idx_nxt_s  = digit_idx_r;
        end
    end

    // Pending and active data updates. A load on the boundary cycle bypasses pending.
    always_comb begin
        pend_data_nxt_s  = pend_data_r;
        pend_blank_nxt_s = pend_blank_r;
        pend_blink_nxt_s = pend_blink_r;
        pend_valid_nxt_s = pend_valid_r;
        act_data_nxt_s   = act_data_r;
        act_blank_nxt_s  = act_blank_r;
        act_blink_nxt_s  = act_blink_r;
        act_valid_nxt_s  = act_valid_r;
        if (frame_end_s) begin
            pend_valid_nxt_s = 1'b0;
            if (load) begin
                act_data_nxt_s  = digit_data;
                act_blank_nxt_s = blank_mask;
                act_blink_nxt_s = blink_mask;
                act_valid_nxt_s = 1'b1;
            end else if (pend_valid_r) begin
                act_data_nxt_s  = pend_data_r;
                act_blank_nxt_s = pend_blank_r;
                act_blink_nxt_s = pend_blink_r;
                act_valid_nxt_s = 1'b1;
            end else begin
                act_valid_nxt_s = act_valid_r;
            end
        end else if (load) begin
            pend_data_nxt_s  = digit_data;
            pend_blank_nxt_s = blank_mask;
            pend_blink_nxt_s = blink_mask;
            pend_valid_nxt_s = 1'b1;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Blink frame counter and phase. Both change only at frame boundaries.
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        blink_on_nxt_s  = blink_on_r;
        if (frame_end_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_nxt_s = BLINK_ZERO;
                blink_on_nxt_s  = ~blink_on_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BLINK_ONE;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Segment and anode values for the next cycle. The glyph uses the active
    // set as it will be after this edge. Until the first data is applied
    // after reset, the display stays dark.
    always_comb begin
        data_shift_s  = act_data_nxt_s >> {idx_nxt_s, 2'b00};
        blank_shift_s = act_blank_nxt_s >> idx_nxt_s;
        blink_shift_s = act_blink_nxt_s >> idx_nxt_s;
        nib_s         = data_shift_s[3:0];
        dark_s        = !act_valid_nxt_s || blank_shift_s[0] ||
                        (blink_shift_s[0] && !blink_on_nxt_s);
        if (dark_s) begin
            seg_nxt_s = SEG_DARK;
        end else begin
            seg_nxt_s = hex_to_seg_n(nib_s);
        end
        if (slot_nxt_s < GUARD_END) begin
            an_nxt_s = '1;
        end else begin
            an_nxt_s = ~(AN_ONE << idx_nxt_s);
        end
    end

    // Scan position registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_r  <= SLOT_ZERO;
            digit_idx_r <= IDX_ZERO;
        end else begin
            slot_cnt_r  <= slot_nxt_s;
            digit_idx_r <= idx_nxt_s;
        end
    end

    // Pending and active display data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_data_r  <= '0;
            pend_blank_r <= '0;
            pend_blink_r <= '0;
            pend_valid_r <= 1'b0;
            act_data_r   <= '0;
            act_blank_r  <= '0;
            act_blink_r  <= '0;
            act_valid_r  <= 1'b0;
        end else begin
            pend_data_r  <= pend_data_nxt_s;
            pend_blank_r <= pend_blank_nxt_s;
            pend_blink_r <= pend_blink_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            act_data_r   <= act_data_nxt_s;
            act_blank_r  <= act_blank_nxt_s;
            act_blink_r  <= act_blink_nxt_s;
            act_valid_r  <= act_valid_nxt_s;
        end
    end

    // Blink state registers. The phase resets to visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= BLINK_ZERO;
            blink_on_r  <= 1'b1;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_on_r  <= blink_on_nxt_s;
        end
    end

    // Registered outputs. seg_n changes only at slot start; frame_done follows the boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_n_r      <= SEG_DARK;
            an_n_r       <= '1;
            frame_done_r <= 1'b0;
        end else begin
            if (slot_nxt_s == SLOT_ZERO) begin
                seg_n_r <= seg_nxt_s;
            end else begin
                seg_n_r <= seg_n_r;
            end
            an_n_r       <= an_nxt_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign seg_n      = seg_n_r;
    assign an_n       = an_n_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner with 4 digits, 8-clock slots, a 2-clock guard
// and 2-frame blink half-periods. Each table row describes one 32-cycle frame.
// A row holds the loads driven during that frame and the glyph expected in each
// digit slot of that same frame. Expected glyphs go into a queue when the frame
// starts, and each one is popped when its slot begins on the outputs.
module tb_seven_seg_scanner;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] digit_data;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int tests;
    int fails;

    logic [6:0] exp_q[$];

    typedef struct {
        string       nm;
        logic        ld_a;
        int          cyc_a;
        logic [15:0] data_a;
        logic        ld_b;
        int          cyc_b;
        logic [15:0] data_b;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [3:0][6:0] exp;
    } vec_t;

    vec_t tbl1[13];
    vec_t tbl2[3];

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .GUARD       (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .digit_data (digit_data),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string nm, input logic ld_a, input int cyc_a,
                                input logic [15:0] data_a, input logic ld_b, input int cyc_b,
                                input logic [15:0] data_b, input logic [3:0] blank,
                                input logic [3:0] blink, input logic [27:0] e);
        vec_t v;
        v.nm = nm; v.ld_a = ld_a; v.cyc_a = cyc_a; v.data_a = data_a;
        v.ld_b = ld_b; v.cyc_b = cyc_b; v.data_b = data_b;
        v.blank = blank; v.blink = blink; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Runs one frame from cycle 0, starting just after a negedge at the frame start.
    task automatic run_frame(input vec_t v, input bit first);
        logic [6:0] cur;
        logic [3:0] an_e;
        int slot;
        int dig;
        for (int k = 0; k < 4; k++) exp_q.push_back(v.exp[k]);
        cur = 7'h7F;
        for (int ci = 0; ci < 32; ci++) begin
            slot = ci % 8;
            dig  = ci / 8;
            if (slot == 0) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    tests++;
                    $display("FAIL %s queue: got empty expected entry", v.nm);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            an_e = 4'hF;
            if (slot >= 2) an_e[dig] = 1'b0;
            chk($sformatf("%s an_n c%0d", v.nm, ci), {28'd0, an_n}, {28'd0, an_e});
            chk($sformatf("%s frame_done c%0d", v.nm, ci), {31'd0, frame_done},
                {31'd0, (ci == 0 && !first)});
            chk($sformatf("%s seg_n c%0d", v.nm, ci), {25'd0, seg_n}, {25'd0, cur});
            load = 1'b0;
            if (v.ld_a && ci == v.cyc_a) begin
                load = 1'b1; digit_data = v.data_a;
                blank_mask = v.blank; blink_mask = v.blink;
            end
            if (v.ld_b && ci == v.cyc_b) begin
                load = 1'b1; digit_data = v.data_b;
                blank_mask = v.blank; blink_mask = v.blink;
            end
            @(posedge clk);
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        load = 1'b0;
        digit_data = 16'h0000;
        blank_mask = 4'h0;
        blink_mask = 4'h0;

        //                name     ldA  cA     dataA   ldB  cB     dataB  blank  blink   {d3,d2,d1,d0}
        tbl1[0]  = mk("f0_idle",  1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h7F,7'h7F,7'h7F,7'h7F});
        tbl1[1]  = mk("f1_ld",    1'b1, 5,  16'h3210, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h7F,7'h7F,7'h7F,7'h7F});
        tbl1[2]  = mk("f2_0123",  1'b1, 20, 16'hFEDC, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h30,7'h24,7'h79,7'h40});
        tbl1[3]  = mk("f3_cdef",  1'b1, 0,  16'hBA98, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h0E,7'h06,7'h21,7'h46});
        tbl1[4]  = mk("f4_tear",  1'b1, 9,  16'h1111, 1'b1, 12, 16'h2222, 4'h0, 4'h0, {7'h03,7'h08,7'h10,7'h00});
        tbl1[5]  = mk("f5_last",  1'b1, 31, 16'hAAAA, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h24,7'h24,7'h24,7'h24});
        tbl1[6]  = mk("f6_bnd",   1'b1, 3,  16'h7654, 1'b0, 0, 16'h0000, 4'h1, 4'h4, {7'h08,7'h08,7'h08,7'h08});
        tbl1[7]  = mk("f7_off",   1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h7F,7'h12,7'h7F});
        tbl1[8]  = mk("f8_on",    1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h02,7'h12,7'h7F});
        tbl1[9]  = mk("f9_on",    1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h02,7'h12,7'h7F});
        tbl1[10] = mk("f10_off",  1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h7F,7'h12,7'h7F});
        tbl1[11] = mk("f11_off",  1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h7F,7'h12,7'h7F});
        tbl1[12] = mk("f12_on",   1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h78,7'h02,7'h12,7'h7F});

        tbl2[0]  = mk("r0_dark",  1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h7F,7'h7F,7'h7F,7'h7F});
        tbl2[1]  = mk("r1_ld",    1'b1, 31, 16'h3214, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h7F,7'h7F,7'h7F,7'h7F});
        tbl2[2]  = mk("r2_show",  1'b0, 0,  16'h0000, 1'b0, 0, 16'h0000, 4'h0, 4'h0, {7'h30,7'h24,7'h79,7'h19});

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset seg_n", {25'd0, seg_n}, {25'd0, 7'h7F});
        chk("reset an_n", {28'd0, an_n}, {28'd0, 4'hF});
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) run_frame(tbl1[i], (i == 0));

        // Advance to digit 2, cycle 5, then assert reset between clock edges
        for (int ci = 0; ci < 21; ci++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-reset an_n lit", {28'd0, an_n}, {28'd0, 4'hB});
        #2 reset_n = 1'b0;
        #1;
        chk("async seg_n", {25'd0, seg_n}, {25'd0, 7'h7F});
        chk("async an_n", {28'd0, an_n}, {28'd0, 4'hF});
        chk("async frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("held seg_n", {25'd0, seg_n}, {25'd0, 7'h7F});
        chk("held an_n", {28'd0, an_n}, {28'd0, 4'hF});
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) run_frame(tbl2[i], (i == 0));

        chk("queue drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
